alu_shift_seq: RTL



---
 rtl/alu_shift_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// Counted shift/rotate engine: repeats one single-bit shift or rotate per clock.
// Define ALU_SHIFT_SEQ_BARREL_EN to compute every step in the acceptance cycle.
module alu_shift_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] operand_a,
    input  logic [2:0] alu_op,
    input  logic [2:0] count,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_c
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       accept;

    // One step, returned as {bit shifted out, new value}.
    function automatic logic [8:0] shift_step(input logic [7:0] v,
                                              input logic [2:0] op);
        logic left;
        logic edge_bit;
        logic cin;
        left     = ~op[2];
        edge_bit = left ? v[7] : v[0];
        unique case (op[1:0])
            2'd0: cin = edge_bit;
            2'd1: cin = 1'b1;
            2'd2: cin = 1'b0;
            2'd3: cin = ~edge_bit;
        endcase
        if (left)
            shift_step = {v[7], v[6:0], cin};
        else
            shift_step = {v[0], cin, v[7:1]};
    endfunction

    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

`ifdef ALU_SHIFT_SEQ_BARREL_EN

    logic [8:0] barrel;

    always_comb begin
        barrel = {1'b0, operand_a};
        for (int i = 0; i < 7; i++) begin
            if (3'(i) < count)
                barrel = shift_step(barrel[7:0], alu_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= 8'h00;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (accept) begin
            state  <= DONE;
            result <= barrel[7:0];
            flag_c <= barrel[8];
            flag_z <= (barrel[7:0] == 8'h00);
            flag_n <= barrel[7];
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

`else

    logic [7:0] work;
    logic [2:0] op_q;
    logic [2:0] remaining;
    logic [8:0] nxt;

    assign nxt = shift_step(work, op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= 8'h00;
            op_q      <= 3'd0;
            remaining <= 3'd0;
            result    <= 8'h00;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
        end else if (accept) begin
            work      <= operand_a;
            op_q      <= alu_op;
            remaining <= count;
            if (count == 3'd0) begin
                // Zero count completes at once with nothing shifted out.
                state  <= DONE;
                result <= operand_a;
                flag_c <= 1'b0;
                flag_z <= (operand_a == 8'h00);
                flag_n <= operand_a[7];
            end else begin
                state <= RUN;
            end
        end else if (state == RUN) begin
            work      <= nxt[7:0];
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
                state  <= DONE;
                result <= nxt[7:0];
                flag_c <= nxt[8];
                flag_z <= (nxt[7:0] == 8'h00);
                flag_n <= nxt[7];
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

`endif

endmodule
